// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed seven-segment scanner with frame-buffered BCD inputs
//
// Purpose: scans temperature (right pair) and setpoint (left pair) onto a
// common-anode display one digit per slot, with an anode-off guard at the
// start of every slot. Inputs are captured only at frame boundaries.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   bcd_temp  - packed BCD temperature {tens, ones}
//   bcd_set   - packed BCD setpoint {tens, ones}
//   an        - active-low anodes, an[0] rightmost
//   seg       - active-low cathodes {g,f,e,d,c,b,a}
//   dp        - active-low decimal point (lit in setpoint-ones slot)
//
// Optional: define SEVEN_SEG_LZ_BLANK_EN to blank a zero tens digit of a valid byte.

module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_temp,
  input  logic [7:0] bcd_set,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(BLANK_CYCLES);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    sh_temp_q, sh_temp_d;
  logic [7:0]    sh_set_q, sh_set_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       tick;
  logic       guard;
  logic [7:0] sel_byte;
  logic [3:0] digit;
  logic       byte_ok;
  logic [6:0] glyph;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    sh_temp_d = sh_temp_q;
    sh_set_d  = sh_set_q;
    // Shadows only move on the last cycle of a frame so a frame is never torn.
    if (tick && (idx_q == 2'd3)) begin
      sh_temp_d = bcd_temp;
      sh_set_d  = bcd_set;
    end
  end

  // Decode from the current (pre-load) shadows; new values surface in idx0.
  always_comb begin
    sel_byte = idx_q[1] ? sh_set_q : sh_temp_q;
    digit    = idx_q[0] ? sel_byte[7:4] : sel_byte[3:0];
    byte_ok  = (sel_byte[7:4] <= 4'd9) && (sel_byte[3:0] <= 4'd9);

    case (digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = SEG_DASH;
    endcase

    // A bad nibble anywhere in the byte dashes both of its digits.
    if (!byte_ok) begin
      glyph = SEG_DASH;
    end
`ifdef SEVEN_SEG_LZ_BLANK_EN
    else if (idx_q[0] && (digit == 4'd0)) begin
      glyph = SEG_BLANK;
    end
`endif

    guard = (cnt_q < GUARD_END);
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!guard) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph;
      dp_d  = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      sh_temp_q <= 8'h00;
      sh_set_q  <= 8'h00;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_temp_q <= sh_temp_d;
      sh_set_q  <= sh_set_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

- Time-multiplexed driver for the thermostat's 4-digit common-anode seven-segment display.
- Consumes two packed-BCD bytes: current temperature and setpoint, each produced by the binary-to-BCD converter stage.
- Double-buffers them at frame boundaries, scans one digit at a time, and inserts an anode-off guard interval to suppress ghosting.
- Renders invalid BCD (including the converter's 0xAA out-of-range code) as dashes.

## Interface
- `REFRESH_DIV`, 100000 — clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 1000 — cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `clk`  in  1  — system clock; the block has one clock and all logic is on the rising edge.
- `rst_n`  in  1  — reset, synchronous and active-low.
- `bcd_temp`  in  8  — current temperature, packed BCD: [7:4] tens, [3:0] ones.
- `bcd_set`  in  8  — setpoint, packed BCD, same format.
- `an`  out  4  — digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  — cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1  — decimal point, active-low.

## Operation
- **Prescaler `cnt`**
  - Counts 0..`REFRESH_DIV`-1, then wraps to 0.
  - `tick` = (`cnt` == `REFRESH_DIV`-1).
- **Digit index `idx` (2 bits)**
  - Increments on `tick`, wrapping 3→0.
  - Slot mapping:
    - idx0 = temp ones (`an[0]`)
    - idx1 = temp tens (`an[1]`)
    - idx2 = setpoint ones (`an[2]`)
    - idx3 = setpoint tens (`an[3]`)
- **Shadow registers `sh_temp`, `sh_set`**
  - Load `bcd_temp`/`bcd_set` only on `tick` while `idx`==3, i.e. at the end of a frame.
  - Input changes mid-frame never tear a frame.
- **Validity**
  - A byte is invalid if either nibble > 9.
  - Both digits of an invalid byte show dash (`seg`=7'h3F).
- **Glyphs (`seg`)**
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Blank = 7'h7F.
- **Anodes**
  - During guard (`cnt` < `BLANK_CYCLES`): `an`=4'b1111 and `seg`=7'h7F.
  - Otherwise `an` = ~(4'b0001 << `idx`).
- **Decimal point**
  - `dp`=0 only in the non-guard part of slot idx2, separating setpoint from temperature.
  - `dp`=1 at all other times.

## Timing
- **Reset values:** `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- **Reset state:** `cnt`=0, `idx`=0, `sh_temp`=`sh_set`=8'h00.
- **Output latency:** `an`/`seg`/`dp` are registered. Outputs in cycle t+1 reflect `cnt`, `idx` and the shadows in cycle t.
- **First frame after reset:** the first `BLANK_CYCLES` output cycles are dark. Shadows hold 00 until the end of the first frame, so the first full frame shows zeros.
- **Shadow load and decode:** on the `tick` edge that ends idx3, the shadows load. The output decoded at that same edge still uses the old shadow values. The next slot begins in guard, so new values first appear in the idx0 slot.
- **Frame period:** 4·`REFRESH_DIV` cycles; each digit is lit for `REFRESH_DIV`-`BLANK_CYCLES` cycles.
- **Reset mid-frame:** with `rst_n`=0 sampled at an edge, all outputs and state take reset values at that edge, regardless of `cnt`/`idx`.
- **Invalid byte:** affects exactly the two digits of that byte. The other pair still renders normally.

## Configuration
- Macro `SEVEN_SEG_LZ_BLANK_EN`.
- **Defined:** the tens digit of a *valid* byte whose tens nibble is 0 renders blank (7'h7F), and `an` is still driven for that slot. Example: 07 shows " 7".
- **Undefined:** tens digit 0 renders "0".
- Dash rendering of invalid bytes is unaffected either way.

## Test plan
All scenarios use `REFRESH_DIV`=4, `BLANK_CYCLES`=1.

1. **Normal frame.** Hold `rst_n`=0 2 cycles, then release; `bcd_temp`=8'h72, `bcd_set`=8'h68; skip first frame. Expected per-slot non-guard cycles:
   - `an`=1110/`seg`=7'h24
   - `an`=1101/7'h78
   - `an`=1011/7'h00 with `dp`=0
   - `an`=0111/7'h02
   - Each slot is preceded by one cycle of `an`=1111.
2. **Invalid input.** `bcd_temp`=8'hAA, `bcd_set`=8'h25 → temp slots show 7'h3F; setpoint slots show 7'h12 then 7'h24.
3. **Leading zero.** `bcd_temp`=8'h07.
   - With `SEVEN_SEG_LZ_BLANK_EN`: idx1 shows `seg`=7'h7F, `an`=1101.
   - Without: idx1 shows 7'h40.
4. **Mid-frame change.** Change `bcd_temp` 8'h72→8'h55 during slot idx1 → the remainder of that frame still shows 7/2; the next frame's idx0 shows 7'h12.
5. **Reset mid-frame.** Assert `rst_n`=0 one cycle during slot idx2 → next cycle `an`=1111, `seg`=7'h7F, `dp`=1. After release, the first frame shows "00" in all digits (0 blanks in tens if the macro is defined).
